// File: rtl/pi_txn_queue.sv
`default_nettype none
// ============================================================================
// Module   : pi_txn_queue
// Purpose  : Decodes Pi register writes into 68k bus commands, buffers them
//            in order and issues them one at a time to the bus-cycle engine.
// Revision : 1.0 - initial release
// ============================================================================
module pi_txn_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 24,
    parameter int DW    = 16
) (
    input  logic                   c200m,
    input  logic                   reset_n,
    input  logic [1:0]             pi_sa,
    input  logic [DW-1:0]          pi_sd,
    input  logic                   pi_swe,
    input  logic                   flush,
    output logic                   pi_busy,
    output logic                   op_req,
    output logic [AW-1:0]          op_addr,
    output logic [DW-1:0]          op_data,
    output logic                   op_rw,
    output logic                   op_uds_n,
    output logic                   op_lds_n,
    input  logic                   op_ack,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = AW - DW;

    localparam logic [1:0]    c_SA_DATA    = 2'd0;
    localparam logic [1:0]    c_SA_ADDR_LO = 2'd1;
    localparam logic [1:0]    c_SA_ADDR_HI = 2'd2;
    localparam logic [0:0]    c_ST_IDLE    = 1'b0;
    localparam logic [0:0]    c_ST_WAIT    = 1'b1;
    localparam logic [CW-1:0] c_FULL       = CW'(DEPTH);

    logic [1:0]    r_swe_sync;
    logic          r_swe_d;
    logic          r_evt;
    logic [DW-1:0] r_data_hold;
    logic [DW-1:0] r_addr_lo;

    logic [AW-1:0] r_q_addr [DEPTH];
    logic [DW-1:0] r_q_data [DEPTH];
    logic          r_q_rw   [DEPTH];
    logic          r_q_uds_n[DEPTH];
    logic          r_q_lds_n[DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_txn_open;
    logic          r_rd_wait;

    logic [AW-1:0] r_op_addr;
    logic [DW-1:0] r_op_data;
    logic          r_op_rw;
    logic          r_op_uds_n;
    logic          r_op_lds_n;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          w_issue;
    logic          w_ack_done;

    logic          w_full;
    logic          w_push_req;
    logic          w_push;
    logic          w_new_rw;
    logic          w_new_byte;
    logic [AW-1:0] w_new_addr;
    logic          w_new_uds_n;
    logic          w_new_lds_n;

    // Pi strobe is asynchronous: two-flop synchroniser, then a one-cycle event
    always_ff @(posedge c200m or negedge reset_n) begin
        if (!reset_n) begin
            r_swe_sync <= '0;
            r_swe_d    <= 1'b0;
            r_evt      <= 1'b0;
        end else begin
            r_swe_sync <= {r_swe_sync[0], pi_swe};
            r_swe_d    <= r_swe_sync[1];
            r_evt      <= r_swe_sync[1] & ~r_swe_d;
        end
    end

    always_ff @(posedge c200m or negedge reset_n) begin
        if (!reset_n) begin
            r_data_hold <= '0;
            r_addr_lo   <= '0;
        end else if (r_evt) begin
            if (pi_sa == c_SA_DATA)    r_data_hold <= pi_sd;
            if (pi_sa == c_SA_ADDR_LO) r_addr_lo   <= pi_sd;
        end
    end

    assign w_full      = (r_count == c_FULL);
    assign w_push_req  = r_evt && (pi_sa == c_SA_ADDR_HI);
    // Flush empties the queue, so a push arriving with it always has room
    assign w_push      = w_push_req && (!w_full || flush);
    assign w_new_rw    = pi_sd[9];
    assign w_new_byte  = pi_sd[8];
    assign w_new_addr  = {pi_sd[HW-1:0], r_addr_lo};
    assign w_new_uds_n = w_new_byte &  r_addr_lo[0];
    assign w_new_lds_n = w_new_byte & ~r_addr_lo[0];

    always_ff @(posedge c200m) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr]  <= w_new_addr;
            r_q_data[r_wr_ptr]  <= r_data_hold;
            r_q_rw[r_wr_ptr]    <= w_new_rw;
            r_q_uds_n[r_wr_ptr] <= w_new_uds_n;
            r_q_lds_n[r_wr_ptr] <= w_new_lds_n;
        end
    end

    always_ff @(posedge c200m or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_txn_open <= 1'b0;
            r_rd_wait  <= 1'b0;
            r_op_addr  <= '0;
            r_op_data  <= '0;
            r_op_rw    <= 1'b1;
            r_op_uds_n <= 1'b1;
            r_op_lds_n <= 1'b1;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= CW'(w_push);
            end else begin
                r_rd_ptr <= r_rd_ptr + PW'(w_issue);
                r_count  <= r_count + CW'(w_push) - CW'(w_issue);
            end

            if (flush)
                r_overflow <= 1'b0;
            else if (w_push_req && w_full)
                r_overflow <= 1'b1;

            if (r_evt && (pi_sa == c_SA_ADDR_LO))
                r_txn_open <= 1'b1;
            else if (w_push)
                r_txn_open <= 1'b0;

            // A read holds the Pi until its own bus cycle finishes
            if (w_push && w_new_rw)
                r_rd_wait <= 1'b1;
            else if ((w_ack_done && r_op_rw) ||
                     (flush && !((r_state == c_ST_WAIT) && r_op_rw)))
                r_rd_wait <= 1'b0;

            if (w_issue) begin
                r_op_addr  <= r_q_addr[r_rd_ptr];
                r_op_data  <= r_q_data[r_rd_ptr];
                r_op_rw    <= r_q_rw[r_rd_ptr];
                r_op_uds_n <= r_q_uds_n[r_rd_ptr];
                r_op_lds_n <= r_q_lds_n[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge c200m or negedge reset_n) begin
        if (!reset_n)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_issue) w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (op_ack)  w_state_nxt = c_ST_IDLE;
            default:                w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue    = 1'b0;
        w_ack_done = 1'b0;
        case (r_state)
            c_ST_IDLE: w_issue    = (r_count != '0) && !flush;
            c_ST_WAIT: w_ack_done = op_ack;
            default: ;
        endcase
    end

    // The head entry is shown directly during the issue cycle, then held
    assign op_req   = w_issue;
    assign op_addr  = w_issue ? r_q_addr[r_rd_ptr]  : r_op_addr;
    assign op_data  = w_issue ? r_q_data[r_rd_ptr]  : r_op_data;
    assign op_rw    = w_issue ? r_q_rw[r_rd_ptr]    : r_op_rw;
    assign op_uds_n = w_issue ? r_q_uds_n[r_rd_ptr] : r_op_uds_n;
    assign op_lds_n = w_issue ? r_q_lds_n[r_rd_ptr] : r_op_lds_n;

    assign q_count  = r_count;
    assign overflow = r_overflow;
    assign pi_busy  = r_txn_open | r_rd_wait | w_full;

endmodule
`default_nettype wire

// File: tb/tb_pi_txn_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_pi_txn_queue
// Purpose  : Self-checking bench for pi_txn_queue against a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pi_txn_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic        rw;
        logic        uds_n;
        logic        lds_n;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  pi_sa;
    logic [15:0] pi_sd;
    logic        pi_swe;
    logic        flush;
    logic        pi_busy;
    logic        op_req;
    logic [23:0] op_addr;
    logic [15:0] op_data;
    logic        op_rw;
    logic        op_uds_n;
    logic        op_lds_n;
    logic        op_ack;
    logic [2:0]  q_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pi_txn_queue #(.DEPTH(DEPTH), .AW(24), .DW(16)) dut (
        .c200m(clk), .reset_n(reset_n), .pi_sa(pi_sa), .pi_sd(pi_sd),
        .pi_swe(pi_swe), .flush(flush), .pi_busy(pi_busy), .op_req(op_req),
        .op_addr(op_addr), .op_data(op_data), .op_rw(op_rw),
        .op_uds_n(op_uds_n), .op_lds_n(op_lds_n), .op_ack(op_ack),
        .q_count(q_count), .overflow(overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    cmd_t        mq[$];
    cmd_t        m_fly;
    bit          m_fly_v  = 0;
    bit          m_ovf    = 0;
    bit          m_open   = 0;
    logic [15:0] m_dhold  = '0;
    logic [15:0] m_lo     = '0;
    bit          m_swe_prev = 0;
    int          m_evt_cnt  = 0;

    function automatic cmd_t mk_cmd(input logic [15:0] hi);
        cmd_t c;
        c.addr  = {hi[7:0], m_lo};
        c.data  = m_dhold;
        c.rw    = hi[9];
        c.uds_n = hi[8] ? m_lo[0]  : 1'b0;
        c.lds_n = hi[8] ? ~m_lo[0] : 1'b0;
        return c;
    endfunction

    function automatic bit exp_busy();
        bit rd;
        rd = m_fly_v && m_fly.rw;
        foreach (mq[i]) if (mq[i].rw) rd = 1;
        return m_open || rd || (mq.size() == DEPTH);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int  pre;
        bit  do_pop;
        bit  fire;
        if (!reset_n) begin
            mq.delete();
            m_fly_v = 0; m_ovf = 0; m_open = 0;
            m_dhold = '0; m_lo = '0;
            m_swe_prev = 0; m_evt_cnt = 0;
        end else begin
            pre    = mq.size();
            do_pop = !m_fly_v && (mq.size() > 0) && !flush;
            // a strobe rise takes effect on the third edge after it is first seen
            fire   = (m_evt_cnt == 1);
            if (m_evt_cnt > 0) m_evt_cnt--;
            if (pi_swe && !m_swe_prev) m_evt_cnt = 3;
            m_swe_prev = pi_swe;
            if (m_fly_v && op_ack) m_fly_v = 0;
            if (do_pop) begin
                m_fly   = mq.pop_front();
                m_fly_v = 1;
            end
            if (flush) begin
                mq.delete();
                m_ovf = 0;
            end
            if (fire) begin
                case (pi_sa)
                    2'd0: m_dhold = pi_sd;
                    2'd1: begin m_lo = pi_sd; m_open = 1; end
                    2'd2: begin
                        if (pre < DEPTH || flush) begin
                            mq.push_back(mk_cmd(pi_sd));
                            m_open = 0;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare and issue log ----------------
    bit   chk_en = 0;
    cmd_t log_q[$];

    always @(negedge clk) begin
        bit e_req;
        if (chk_en) begin
            e_req = !m_fly_v && (mq.size() > 0) && !flush;
            check("op_req", op_req, e_req);
            if (e_req) begin
                check("op_addr", op_addr, mq[0].addr);
                check("op_data", op_data, mq[0].data);
                check("op_rw",   op_rw,   mq[0].rw);
                check("op_uds",  op_uds_n, mq[0].uds_n);
                check("op_lds",  op_lds_n, mq[0].lds_n);
            end else if (m_fly_v) begin
                check("hold_addr", op_addr, m_fly.addr);
                check("hold_data", op_data, m_fly.data);
                check("hold_rw",   op_rw,   m_fly.rw);
                check("hold_uds",  op_uds_n, m_fly.uds_n);
                check("hold_lds",  op_lds_n, m_fly.lds_n);
            end
            check("q_count",  q_count, mq.size());
            check("overflow", overflow, m_ovf);
            check("pi_busy",  pi_busy, exp_busy());
        end
        if (op_req) log_q.push_back({op_addr, op_data, op_rw, op_uds_n, op_lds_n});
    end

    // ---------------- bus engine responder ----------------
    bit eng_auto  = 1;
    bit eng_stall = 0;
    bit eng_pend  = 0;
    int eng_delay = 2;
    int eng_wait  = 0;

    initial begin
        op_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_auto) begin
                op_ack = 1'b0;
                if (!reset_n) eng_pend = 0;
                else if (eng_pend) begin
                    if (eng_wait == 0 && !eng_stall) begin
                        op_ack = 1'b1;
                        eng_pend = 0;
                    end else if (eng_wait > 0) eng_wait--;
                end else if (op_req) begin
                    eng_pend = 1;
                    eng_wait = eng_delay;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pi_write(input logic [1:0] sa, input logic [15:0] sd);
        @(posedge clk); #2;
        pi_sa = sa; pi_sd = sd; pi_swe = 1'b1;
        repeat (6) @(posedge clk);
        #2 pi_swe = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic push_cmd(input logic [15:0] data, input logic [15:0] lo, input logic [15:0] hi);
        pi_write(2'd0, data);
        pi_write(2'd1, lo);
        pi_write(2'd2, hi);
    endtask

    task automatic ack_one();
        @(negedge clk); op_ack = 1'b1;
        @(negedge clk); op_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((m_fly_v || mq.size() != 0) && t < 2000) begin @(negedge clk); t++; end
        check("idle_timeout", q_count == 0 && t < 2000, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_req"},  op_req,   0);
        check({tag, "_addr"}, op_addr,  0);
        check({tag, "_data"}, op_data,  0);
        check({tag, "_rw"},   op_rw,    1);
        check({tag, "_uds"},  op_uds_n, 1);
        check({tag, "_lds"},  op_lds_n, 1);
        check({tag, "_cnt"},  q_count,  0);
        check({tag, "_ovf"},  overflow, 0);
        check({tag, "_busy"}, pi_busy,  0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int base;
        reset_n = 1'b0; pi_sa = '0; pi_sd = '0; pi_swe = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #2 reset_n = 1'b1;
        chk_en = 1;

        // word write
        eng_delay = 3;
        pi_write(2'd0, 16'hBEEF);
        pi_write(2'd1, 16'h1234);
        @(negedge clk);
        check("ww_busy_open", pi_busy, 1);
        pi_write(2'd2, 16'h0000);
        @(negedge clk);
        check("ww_busy_done", pi_busy, 0);
        wait_idle();
        check("ww_addr", log_q[0].addr, 24'h001234);
        check("ww_data", log_q[0].data, 16'hBEEF);
        check("ww_rw",   log_q[0].rw, 0);
        check("ww_uds",  log_q[0].uds_n, 0);
        check("ww_lds",  log_q[0].lds_n, 0);

        // byte read at odd address, slow engine
        eng_delay = 40;
        pi_write(2'd1, 16'h0001);
        pi_write(2'd2, 16'h0300);
        @(negedge clk);
        check("rd_busy_early", pi_busy, 1);
        repeat (20) @(negedge clk);
        check("rd_busy_mid", pi_busy, 1);
        wait_idle();
        @(negedge clk);
        check("rd_busy_done", pi_busy, 0);
        check("rd_addr", log_q[1].addr, 24'h000001);
        check("rd_rw",   log_q[1].rw, 1);
        check("rd_uds",  log_q[1].uds_n, 1);
        check("rd_lds",  log_q[1].lds_n, 0);

        // ordering and overflow with a stalled engine
        eng_delay = 1;
        eng_stall = 1;
        for (int i = 0; i < 6; i++) begin
            push_cmd(16'hA000 + 16'(i), 16'h0100 + 16'(2 * i), 16'h0000);
            @(negedge clk);
            if (i == 4) begin
                check("full_count", q_count, 4);
                check("full_busy",  pi_busy, 1);
                check("full_ovf",   overflow, 0);
            end
        end
        check("ovf_set",   overflow, 1);
        check("ovf_count", q_count, 4);
        eng_stall = 0;
        wait_idle();
        for (int i = 0; i < 5; i++)
            check("order_data", log_q[2 + i].data, 16'hA000 + 16'(i));
        check("order_len", log_q.size(), 7);

        // push coinciding with op_ack, two entries queued
        eng_auto = 0;
        @(negedge clk); op_ack = 1'b0;
        for (int i = 0; i < 3; i++)
            push_cmd(16'hB000 + 16'(i), 16'h0200 + 16'(2 * i), 16'h0000);
        @(negedge clk);
        check("pa_pre_count", q_count, 2);
        pi_write(2'd0, 16'hB003);
        pi_write(2'd1, 16'h0206);
        fork
            pi_write(2'd2, 16'h0000);
            begin
                @(posedge clk);
                repeat (4) @(negedge clk);
                op_ack = 1'b1;
                @(negedge clk);
                op_ack = 1'b0;
                check("pa_req_next", op_req, 1);
                @(negedge clk);
                check("pa_count", q_count, 2);
            end
        join
        repeat (3) ack_one();
        wait_idle();
        for (int i = 0; i < 4; i++)
            check("pa_order", log_q[7 + i].data, 16'hB000 + 16'(i));

        // flush with a read in flight and three writes queued
        base = log_q.size();
        pi_write(2'd1, 16'h0300);
        pi_write(2'd2, 16'h0200);
        for (int i = 0; i < 3; i++)
            push_cmd(16'hC000 + 16'(i), 16'h0310 + 16'(2 * i), 16'h0000);
        @(negedge clk);
        check("fl_pre_count", q_count, 3);
        check("fl_pre_ovf",   overflow, 1);
        @(posedge clk); #2 flush = 1'b1;
        @(posedge clk); #2 flush = 1'b0;
        @(negedge clk);
        check("fl_count", q_count, 0);
        check("fl_ovf",   overflow, 0);
        check("fl_busy",  pi_busy, 1);
        repeat (10) @(negedge clk);
        check("fl_no_req", log_q.size(), base + 1);
        ack_one();
        check("fl_busy_done", pi_busy, 0);

        // asynchronous reset while a command is in flight
        push_cmd(16'hD000, 16'h0400, 16'h0000);
        push_cmd(16'hD001, 16'h0402, 16'h0000);
        @(negedge clk);
        check("ar_pre_count", q_count, 1);
        @(posedge clk); #3 reset_n = 1'b0;
        #1 chk_reset_vals("arst");
        @(posedge clk); #2 reset_n = 1'b1;
        base = log_q.size();
        repeat (10) @(negedge clk);
        check("ar_no_req", log_q.size(), base);
        pi_write(2'd1, 16'h0500);
        pi_write(2'd2, 16'h0000);
        @(negedge clk);
        check("ar_new_req", log_q.size(), base + 1);
        check("ar_new_addr", log_q[base].addr, 24'h000500);
        ack_one();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
